// File: rtl/switchres_loader.sv
// switchres_loader: on a cmd_switchres request, fetch a 3-word modeline from DDR,
// validate it, commit it to the shadow video-timing registers and acknowledge the
// request with a one-cycle reset_switchres pulse.
// Build option: define SWITCHRES_VBLANK_SYNC_EN to defer the commit to the next
// vga_vblank rising edge; when undefined the commit is immediate and may tear a frame.

module switchres_loader #(
    parameter int unsigned       DDR_AW    = 29,
    parameter logic [DDR_AW-1:0] BASE_ADDR = '0,
    parameter logic [15:0]       TIMEOUT   = 16'd4096
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cmd_switchres,
    output logic              reset_switchres,
    input  logic              vga_vblank,
    input  logic              ddr_busy,
    output logic              ddr_rd,
    output logic [DDR_AW-1:0] ddr_addr,
    input  logic [63:0]       ddr_dout,
    input  logic              ddr_dout_ready,
    output logic [15:0]       h_active,
    output logic [15:0]       h_begin,
    output logic [15:0]       h_end,
    output logic [15:0]       h_total,
    output logic [15:0]       v_active,
    output logic [15:0]       v_begin,
    output logic [15:0]       v_end,
    output logic [15:0]       v_total,
    output logic [7:0]        ce_div,
    output logic              interlace,
    output logic              timing_valid,
    output logic              mode_update,
    output logic              sw_err,
    output logic              sw_busy
);

    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    // 640x480@60 defaults, packed as {total, end, begin, active}
    localparam logic [63:0] H_RST  = {16'd800, 16'd752, 16'd656, 16'd640};
    localparam logic [63:0] V_RST  = {16'd525, 16'd492, 16'd490, 16'd480};
    localparam logic [7:0]  CE_RST = 8'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_ARM,
        S_APPLY,
        S_ACK,
        S_DONE
    } state_t;

    state_t            st_q;
    logic [1:0]        idx_q;
    logic [DDR_AW-1:0] addr_q;
    logic [15:0]       tmo_q;

    // staging copy of the fetched modeline
    logic [63:0]       stg_h_q;
    logic [63:0]       stg_v_q;
    logic [7:0]        stg_ce_q;
    logic              stg_il_q;

    // committed timing
    logic [63:0]       h_q;
    logic [63:0]       v_q;
    logic [7:0]        ce_q;
    logic              il_q;

    logic              valid_q;
    logic              mode_update_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;
    logic              modeline_ok_c;

    // 0 < active < begin < end <= total on one {total, end, begin, active} word
    function automatic logic timing_ok(input logic [63:0] w);
        logic [15:0] act;
        logic [15:0] beg;
        logic [15:0] fin;
        logic [15:0] tot;
        act = w[15:0];
        beg = w[31:16];
        fin = w[47:32];
        tot = w[63:48];
        return (act != 16'd0) && (act < beg) && (beg < fin) && (fin <= tot);
    endfunction

    // Whole-modeline validity check on the staged words
    assign modeline_ok_c = timing_ok(stg_h_q) && timing_ok(stg_v_q) && (stg_ce_q != 8'd0);

`ifdef SWITCHRES_VBLANK_SYNC_EN
    logic vblank_q;
    logic vblank_rise_c;

    assign vblank_rise_c = vga_vblank & ~vblank_q;

    // Vblank edge detector, free-running in every state
    always_ff @(posedge clk_sys) begin
        if (reset) vblank_q <= 1'b0;
        else       vblank_q <= vga_vblank;
    end
`else
    logic unused_vblank;
    assign unused_vblank = vga_vblank;
`endif

    // Read strobe follows the port's ready so a busy stall releases without a bubble
    assign ddr_rd   = (st_q == S_REQ) && !ddr_busy;
    assign ddr_addr = addr_q;

    // Load sequencer: fetch, validate, optionally wait for vblank, commit, acknowledge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            st_q          <= S_IDLE;
            idx_q         <= 2'd0;
            addr_q        <= BASE_ADDR;
            tmo_q         <= 16'd0;
            stg_h_q       <= H_RST;
            stg_v_q       <= V_RST;
            stg_ce_q      <= CE_RST;
            stg_il_q      <= 1'b0;
            h_q           <= H_RST;
            v_q           <= V_RST;
            ce_q          <= CE_RST;
            il_q          <= 1'b0;
            valid_q       <= 1'b0;
            mode_update_q <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mode_update_q <= 1'b0;
            ack_q         <= 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (cmd_switchres) begin
                        err_q  <= 1'b0;
                        idx_q  <= 2'd0;
                        addr_q <= BASE_ADDR;
                        busy_q <= 1'b1;
                        st_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!ddr_busy) begin
                        tmo_q <= 16'd0;
                        st_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ddr_dout_ready) begin
                        if (idx_q == 2'd0) begin
                            stg_h_q <= ddr_dout;
                        end else if (idx_q == 2'd1) begin
                            stg_v_q <= ddr_dout;
                        end else begin
                            stg_ce_q <= ddr_dout[7:0];
                            stg_il_q <= ddr_dout[8];
                        end
                        if (idx_q == 2'd2) begin
                            st_q <= S_CHECK;
                        end else begin
                            idx_q  <= idx_q + 2'd1;
                            addr_q <= addr_q + DDR_AW'(1);
                            st_q   <= S_REQ;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q <= 1'b1;
                        st_q  <= S_ACK;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (modeline_ok_c) begin
                        st_q <= S_ARM;
                    end else begin
                        err_q <= 1'b1;
                        st_q  <= S_ACK;
                    end
                end
                S_ARM: begin
`ifdef SWITCHRES_VBLANK_SYNC_EN
                    if (vblank_rise_c) st_q <= S_APPLY;
`else
                    st_q <= S_APPLY;
`endif
                end
                S_APPLY: begin
                    h_q           <= stg_h_q;
                    v_q           <= stg_v_q;
                    ce_q          <= stg_ce_q;
                    il_q          <= stg_il_q;
                    valid_q       <= 1'b1;
                    mode_update_q <= 1'b1;
                    st_q          <= S_ACK;
                end
                S_ACK: begin
                    ack_q <= 1'b1;
                    st_q  <= S_DONE;
                end
                S_DONE: begin
                    // hold here until the request level drops so it cannot re-trigger
                    if (!cmd_switchres) begin
                        busy_q <= 1'b0;
                        st_q   <= S_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    st_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign h_active        = h_q[15:0];
    assign h_begin         = h_q[31:16];
    assign h_end           = h_q[47:32];
    assign h_total         = h_q[63:48];
    assign v_active        = v_q[15:0];
    assign v_begin         = v_q[31:16];
    assign v_end           = v_q[47:32];
    assign v_total         = v_q[63:48];
    assign ce_div          = ce_q;
    assign interlace       = il_q;
    assign timing_valid    = valid_q;
    assign mode_update     = mode_update_q;
    assign reset_switchres = ack_q;
    assign sw_err          = err_q;
    assign sw_busy         = busy_q;

endmodule

// File: tb/tb_switchres_loader.sv
// Directed bench for switchres_loader: a zero-wait DDR responder model plus
// scenario tasks with hand-computed expectations. Works with or without
// SWITCHRES_VBLANK_SYNC_EN defined.

module tb_switchres_loader;

    localparam int unsigned   AW   = 29;
    localparam logic [AW-1:0] BASE = 29'h100;
    localparam logic [15:0]   TMO  = 16'd64;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_switchres = 1'b0;
    logic          reset_switchres;
    logic          vga_vblank = 1'b0;
    logic          ddr_busy = 1'b0;
    logic          ddr_rd;
    logic [AW-1:0] ddr_addr;
    logic [63:0]   ddr_dout = 64'd0;
    logic          ddr_dout_ready = 1'b0;
    logic [15:0]   h_active, h_begin, h_end, h_total;
    logic [15:0]   v_active, v_begin, v_end, v_total;
    logic [7:0]    ce_div;
    logic          interlace, timing_valid, mode_update, sw_err, sw_busy;

    always #5 clk_sys = ~clk_sys;

    switchres_loader #(
        .DDR_AW    (AW),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cmd_switchres   (cmd_switchres),
        .reset_switchres (reset_switchres),
        .vga_vblank      (vga_vblank),
        .ddr_busy        (ddr_busy),
        .ddr_rd          (ddr_rd),
        .ddr_addr        (ddr_addr),
        .ddr_dout        (ddr_dout),
        .ddr_dout_ready  (ddr_dout_ready),
        .h_active        (h_active),
        .h_begin         (h_begin),
        .h_end           (h_end),
        .h_total         (h_total),
        .v_active        (v_active),
        .v_begin         (v_begin),
        .v_end           (v_end),
        .v_total         (v_total),
        .ce_div          (ce_div),
        .interlace       (interlace),
        .timing_valid    (timing_valid),
        .mode_update     (mode_update),
        .sw_err          (sw_err),
        .sw_busy         (sw_busy)
    );

    int checks = 0;
    int failures = 0;

    // DDR model / event monitor state
    int            rd_count = 0;
    int            grant_count = 0;
    int            served_count = 0;
    int            resp_limit = 0;
    int            inject_req = 0;
    int            inject_done = 0;
    int            mu_count = 0;
    int            ack_count = 0;
    logic [AW-1:0] rd_addr    [0:15];
    logic [AW-1:0] grant_addr [0:15];
    logic [63:0]   mem        [0:3];

    function automatic logic [63:0] mkw(input int unsigned t, input int unsigned e,
                                        input int unsigned b, input int unsigned a);
        return {t[15:0], e[15:0], b[15:0], a[15:0]};
    endfunction

    // Log read strobes and output pulses as the DUT presents them at each edge
    always @(posedge clk_sys) begin
        if (ddr_rd === 1'b1) begin
            rd_addr[rd_count[3:0]] = ddr_addr;
            rd_count++;
            if (grant_count < resp_limit) begin
                grant_addr[grant_count[3:0]] = ddr_addr;
                grant_count++;
            end
        end
        if (mode_update === 1'b1) mu_count++;
        if (reset_switchres === 1'b1) ack_count++;
    end

    // Return granted reads one cycle after the strobe; also emit injected stray responses
    always @(negedge clk_sys) begin
        logic [AW-1:0] off;
        ddr_dout_ready = 1'b0;
        if (served_count < grant_count) begin
            off = grant_addr[served_count[3:0]] - BASE;
            ddr_dout = mem[off[1:0]];
            ddr_dout_ready = 1'b1;
            served_count++;
        end else if (inject_done < inject_req) begin
            ddr_dout = mem[0];
            ddr_dout_ready = 1'b1;
            inject_done++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        cmd_switchres = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({h_total, h_end, h_begin, h_active} !== mkw(800, 752, 656, 640)) begin
            failures++;
            $display("FAIL reset_h: got %0d/%0d/%0d/%0d want 640/656/752/800", h_active, h_begin, h_end, h_total);
        end
        checks++;
        if ({v_total, v_end, v_begin, v_active} !== mkw(525, 492, 490, 480)) begin
            failures++;
            $display("FAIL reset_v: got %0d/%0d/%0d/%0d want 480/490/492/525", v_active, v_begin, v_end, v_total);
        end
        checks++;
        if (ce_div !== 8'd4) begin
            failures++;
            $display("FAIL reset_ce_div: got %0d want 4", ce_div);
        end
        checks++;
        if ({interlace, timing_valid, mode_update, sw_err, sw_busy, reset_switchres, ddr_rd} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {interlace, timing_valid, mode_update, sw_err, sw_busy, reset_switchres, ddr_rd});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if ({sw_busy, ddr_rd} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b rd=%b want 0 0", sw_busy, ddr_rd);
        end
    endtask

    task automatic test_valid_720p();
        int base_rd, base_ack, lat, early;
        mem[0] = mkw(1650, 1430, 1390, 1280);
        mem[1] = mkw(750, 730, 725, 720);
        mem[2] = 64'd1;
        base_rd = rd_count;
        base_ack = ack_count;
        resp_limit = grant_count + 3;
        vga_vblank = 1'b0;
        cmd_switchres = 1'b1;
        lat = 0;
        early = 0;
`ifdef SWITCHRES_VBLANK_SYNC_EN
        repeat (25) @(negedge clk_sys);
        checks++;
        if (mu_count !== 0 || h_total !== 16'd800 || sw_busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_until_vblank: got mu=%0d h_total=%0d busy=%b want 0 800 1", mu_count, h_total, sw_busy);
        end
        vga_vblank = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (mode_update !== 1'b0) begin
            failures++;
            $display("FAIL apply_cycle: got mode_update=%b want 0", mode_update);
        end
        @(negedge clk_sys);
        checks++;
        if (mode_update !== 1'b1) begin
            failures++;
            $display("FAIL vblank_commit: got mode_update=%b want 1", mode_update);
        end
`else
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk_sys);
            if (mode_update === 1'b1) lat = k;
            else if (h_total !== 16'd800) early++;
        end
        checks++;
        if (lat != 10) begin
            failures++;
            $display("FAIL latency: got %0d edges after request want 10", lat);
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL early_change: got %0d cycles with changed output want 0", early);
        end
`endif
        checks++;
        if (rd_count - base_rd != 3) begin
            failures++;
            $display("FAIL read_count: got %0d want 3", rd_count - base_rd);
        end
        for (int i = 0; i < 3; i++) begin
            int j;
            j = base_rd + i;
            checks++;
            if (rd_addr[j[3:0]] !== BASE + AW'(i)) begin
                failures++;
                $display("FAIL read_addr%0d: got %h want %h", i, rd_addr[j[3:0]], BASE + AW'(i));
            end
        end
        checks++;
        if ({h_total, h_end, h_begin, h_active} !== mkw(1650, 1430, 1390, 1280) ||
            {v_total, v_end, v_begin, v_active} !== mkw(750, 730, 725, 720)) begin
            failures++;
            $display("FAIL commit_720p: got h_total=%0d v_total=%0d want 1650 750", h_total, v_total);
        end
        checks++;
        if ({timing_valid, ce_div, interlace, sw_err} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL commit_flags: got valid=%b ce=%0d il=%b err=%b want 1 1 0 0", timing_valid, ce_div, interlace, sw_err);
        end
        @(negedge clk_sys);
        checks++;
        if ({reset_switchres, mode_update} !== 2'b10) begin
            failures++;
            $display("FAIL ack_after_update: got ack=%b mu=%b want 1 0", reset_switchres, mode_update);
        end
        @(negedge clk_sys);
        checks++;
        if (reset_switchres !== 1'b0 || ack_count - base_ack != 1) begin
            failures++;
            $display("FAIL ack_single: got ack=%b pulses=%0d want 0 1", reset_switchres, ack_count - base_ack);
        end
        cmd_switchres = 1'b0;
        vga_vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (sw_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_drop: got busy=%b want 0", sw_busy);
        end
    endtask

    task automatic test_invalid();
        int base_mu, base_ack, seen;
        logic prev_err, err_before_ack;
        mem[0] = mkw(1650, 1700, 1390, 1280);
        mem[1] = mkw(750, 730, 725, 720);
        mem[2] = 64'd1;
        base_mu = mu_count;
        base_ack = ack_count;
        resp_limit = grant_count + 3;
        cmd_switchres = 1'b1;
        seen = 0;
        prev_err = 1'b0;
        err_before_ack = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_sys);
            vga_vblank = (k % 8) >= 4;
            if (reset_switchres === 1'b1 && seen == 0) begin
                seen = 1;
                err_before_ack = prev_err;
            end
            prev_err = sw_err;
        end
        checks++;
        if (sw_err !== 1'b1 || err_before_ack !== 1'b1) begin
            failures++;
            $display("FAIL invalid_err: got err=%b err_before_ack=%b want 1 1", sw_err, err_before_ack);
        end
        checks++;
        if (ack_count - base_ack != 1 || mu_count != base_mu) begin
            failures++;
            $display("FAIL invalid_pulses: got acks=%0d updates=%0d want 1 0", ack_count - base_ack, mu_count - base_mu);
        end
        checks++;
        if ({h_total, h_end, h_begin, h_active} !== mkw(1650, 1430, 1390, 1280) || ce_div !== 8'd1) begin
            failures++;
            $display("FAIL invalid_keeps: got h_end=%0d h_total=%0d ce=%0d want 1430 1650 1", h_end, h_total, ce_div);
        end
        cmd_switchres = 1'b0;
        vga_vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if ({sw_busy, sw_err} !== 2'b01) begin
            failures++;
            $display("FAIL err_sticky: got busy=%b err=%b want 0 1", sw_busy, sw_err);
        end
    endtask

    task automatic test_timeout();
        int base_rd, base_mu, base_ack, lat;
        mem[0] = mkw(1650, 1430, 1390, 1280);
        mem[1] = mkw(750, 730, 725, 720);
        mem[2] = 64'd1;
        base_rd = rd_count;
        base_mu = mu_count;
        base_ack = ack_count;
        resp_limit = grant_count + 1;
        cmd_switchres = 1'b1;
        for (int k = 0; k < 40 && (rd_count - base_rd) < 2; k++) @(negedge clk_sys);
        checks++;
        if (rd_count - base_rd != 2 || sw_err !== 1'b0) begin
            failures++;
            $display("FAIL second_read: got reads=%0d err=%b want 2 0", rd_count - base_rd, sw_err);
        end
        lat = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clk_sys);
            if (sw_err === 1'b1) lat = k;
        end
        checks++;
        if (lat != int'(TMO)) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d want %0d", lat, TMO);
        end
        @(negedge clk_sys);
        checks++;
        if (reset_switchres !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ack: got %b want 1", reset_switchres);
        end
        inject_req++;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (sw_busy !== 1'b1 || rd_count - base_rd != 2 || mu_count != base_mu) begin
            failures++;
            $display("FAIL late_in_done: got busy=%b reads=%0d updates=%0d want 1 2 0", sw_busy, rd_count - base_rd, mu_count - base_mu);
        end
        cmd_switchres = 1'b0;
        repeat (2) @(negedge clk_sys);
        inject_req++;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (sw_busy !== 1'b0 || rd_count - base_rd != 2 || ack_count - base_ack != 1) begin
            failures++;
            $display("FAIL late_in_idle: got busy=%b reads=%0d acks=%0d want 0 2 1", sw_busy, rd_count - base_rd, ack_count - base_ack);
        end
        checks++;
        if (sw_err !== 1'b1 || h_total !== 16'd1650) begin
            failures++;
            $display("FAIL timeout_keeps: got err=%b h_total=%0d want 1 1650", sw_err, h_total);
        end
    endtask

    task automatic test_hold_cmd();
        int base_rd, base_mu, base_ack, ack_k;
        mem[0] = mkw(2200, 2052, 2008, 1920);
        mem[1] = mkw(1125, 1089, 1084, 1080);
        mem[2] = 64'hDEAD_BEEF_0000_FF02;
        base_rd = rd_count;
        base_mu = mu_count;
        base_ack = ack_count;
        resp_limit = grant_count + 3;
        cmd_switchres = 1'b1;
        ack_k = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_sys);
            vga_vblank = (k % 8) >= 4;
            if (reset_switchres === 1'b1 && ack_k < 0) ack_k = k;
        end
        checks++;
        if (ack_k < 0 || ack_k > 39) begin
            failures++;
            $display("FAIL hold_ack_time: got %0d want 0..39", ack_k);
        end
        checks++;
        if (ack_count - base_ack != 1 || mu_count - base_mu != 1 || rd_count - base_rd != 3) begin
            failures++;
            $display("FAIL hold_single: got acks=%0d updates=%0d reads=%0d want 1 1 3",
                     ack_count - base_ack, mu_count - base_mu, rd_count - base_rd);
        end
        checks++;
        if ({h_total, h_end, h_begin, h_active} !== mkw(2200, 2052, 2008, 1920) ||
            {v_total, v_end, v_begin, v_active} !== mkw(1125, 1089, 1084, 1080)) begin
            failures++;
            $display("FAIL commit_1080: got h_active=%0d v_active=%0d want 1920 1080", h_active, v_active);
        end
        checks++;
        if ({ce_div, interlace, sw_busy} !== {8'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL w2_fields: got ce=%0d il=%b busy=%b want 2 1 1", ce_div, interlace, sw_busy);
        end
        cmd_switchres = 1'b0;
        vga_vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_busy_stall();
        int base_rd, base_mu, bad;
        mem[0] = mkw(1650, 1430, 1390, 1280);
        mem[1] = mkw(750, 730, 725, 720);
        mem[2] = 64'd1;
        base_rd = rd_count;
        base_mu = mu_count;
        resp_limit = grant_count + 3;
        ddr_busy = 1'b1;
        cmd_switchres = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_sys);
            if (ddr_rd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || sw_err !== 1'b0 || sw_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_stall: got rd_cycles=%0d err=%b busy=%b want 0 0 1", bad, sw_err, sw_busy);
        end
        ddr_busy = 1'b0;
        #1;
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== BASE) begin
            failures++;
            $display("FAIL rd_on_release: got rd=%b addr=%h want 1 %h", ddr_rd, ddr_addr, BASE);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_sys);
            vga_vblank = (k % 8) >= 4;
        end
        checks++;
        if (mu_count - base_mu != 1 || rd_count - base_rd != 3 || sw_err !== 1'b0 || h_total !== 16'd1650) begin
            failures++;
            $display("FAIL after_stall: got updates=%0d reads=%0d err=%b h_total=%0d want 1 3 0 1650",
                     mu_count - base_mu, rd_count - base_rd, sw_err, h_total);
        end
        cmd_switchres = 1'b0;
        vga_vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_reset_in_wait();
        int base_rd, base_ack;
        mem[0] = mkw(2200, 2052, 2008, 1920);
        mem[1] = mkw(1125, 1089, 1084, 1080);
        mem[2] = 64'd2;
        base_rd = rd_count;
        base_ack = ack_count;
        resp_limit = grant_count + 1;
        cmd_switchres = 1'b1;
        for (int k = 0; k < 40 && (rd_count - base_rd) < 2; k++) @(negedge clk_sys);
        repeat (3) @(negedge clk_sys);
        checks++;
        if (sw_busy !== 1'b1 || rd_count - base_rd != 2) begin
            failures++;
            $display("FAIL in_wait: got busy=%b reads=%0d want 1 2", sw_busy, rd_count - base_rd);
        end
        reset = 1'b1;
        cmd_switchres = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({h_total, h_end, h_begin, h_active} !== mkw(800, 752, 656, 640) ||
            {v_total, v_end, v_begin, v_active} !== mkw(525, 492, 490, 480) || ce_div !== 8'd4) begin
            failures++;
            $display("FAIL wait_reset_vals: got h_active=%0d v_active=%0d ce=%0d want 640 480 4", h_active, v_active, ce_div);
        end
        checks++;
        if ({sw_busy, interlace, timing_valid, sw_err, mode_update, reset_switchres} !== 6'b0) begin
            failures++;
            $display("FAIL wait_reset_flags: got %b want 000000",
                     {sw_busy, interlace, timing_valid, sw_err, mode_update, reset_switchres});
        end
        reset = 1'b0;
        inject_req++;
        repeat (5) @(negedge clk_sys);
        checks++;
        if (ack_count != base_ack || rd_count - base_rd != 2 || sw_busy !== 1'b0 || h_total !== 16'd800) begin
            failures++;
            $display("FAIL wait_reset_quiet: got acks=%0d reads=%0d busy=%b h_total=%0d want 0 2 0 800",
                     ack_count - base_ack, rd_count - base_rd, sw_busy, h_total);
        end
    endtask

    initial begin
        test_reset();
        test_valid_720p();
        test_invalid();
        test_timeout();
        test_hold_cmd();
        test_busy_stall();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
